// File: rtl/dircc_types_pkg.sv
// Shared DiRCC types: packet and device-state formats, the RTS bit position
// inside user_state, and the receive scheduler state encoding.
package dircc_types_pkg;

    typedef struct packed {
        logic [7:0]  dst_device;
        logic [7:0]  src_device;
        logic [15:0] payload;
    } packet_t;

    typedef struct packed {
        logic [15:0] user_state;
    } dircc_state_t;

    // user_state bit that the handler sets when the device wants to send
    localparam int unsigned DIRCC_RTS_BIT = 15;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_READ,
        RX_CAPTURE,
        RX_HANDLE,
        RX_WRITE
    } dircc_rx_sched_state_t;

endpackage

// File: rtl/dircc_rts_tracker.sv
// Per-device ready-to-send flags. A set from the write-back path overrides a
// clear from the send path that targets the same device in the same cycle.
module dircc_rts_tracker #(
    parameter int unsigned NUM_DEVICES = 4,
    parameter int unsigned DEV_IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [DEV_IDX_W-1:0]   set_idx,
    input  logic                   set_value,
    input  logic                   clr_en,
    input  logic [DEV_IDX_W-1:0]   clr_idx,
    output logic [NUM_DEVICES-1:0] flags
);

    // Flag update; out-of-range indices match no flag and are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
                if (set_en && (32'(set_idx) == i))
                    flags[i] <= set_value;
                else if (clr_en && (32'(clr_idx) == i))
                    flags[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dircc_receive_scheduler.sv
// Receive-path sequencer for one DiRCC processing element: accepts a packet,
// reads the target device state, hands both to the receive handler and writes
// the handler's updated state back, with a bounded wait on the handler.
module dircc_receive_scheduler
    import dircc_types_pkg::*;
#(
    parameter int unsigned NUM_DEVICES     = 4,
    parameter int unsigned DEV_IDX_W       = $clog2(NUM_DEVICES),
    parameter int unsigned HANDLER_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  packet_t                packet_in,
    input  logic                   packet_in_valid,
    output logic                   packet_in_ready,
    output logic                   state_rd_en,
    output logic [DEV_IDX_W-1:0]   state_rd_addr,
    input  dircc_state_t           state_rd_data,
    output logic                   state_wr_en,
    output logic [DEV_IDX_W-1:0]   state_wr_addr,
    output dircc_state_t           state_wr_data,
    output packet_t                handler_packet,
    output logic                   handler_packet_valid,
    output logic                   handler_receive_done,
    output dircc_state_t           handler_read_state,
    input  dircc_state_t           handler_write_state,
    input  logic                   handler_write_state_valid,
    input  logic                   handler_packet_handled,
    output logic [NUM_DEVICES-1:0] rts_pending,
    input  logic                   rts_clear,
    input  logic [DEV_IDX_W-1:0]   rts_clear_idx,
    output logic [31:0]            stat_handled,
    output logic [15:0]            stat_dropped
);

    dircc_rx_sched_state_t state, next_state;

    packet_t              pkt_q;
    dircc_state_t         rd_state_q;
    dircc_state_t         wr_state_q;
    logic [7:0]           tmo_cnt;
    logic                 out_of_reset;
    logic                 drop_idle;
    logic                 complete;
    logic                 timeout;
    logic [DEV_IDX_W-1:0] dst_idx;

    assign dst_idx            = pkt_q.dst_device[DEV_IDX_W-1:0];
    assign state_rd_addr      = dst_idx;
    assign state_wr_addr      = dst_idx;
    assign state_wr_data      = wr_state_q;
    assign handler_packet     = pkt_q;
    assign handler_read_state = rd_state_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= next_state;
    end

    // Next-state and control decode; ready is held low until the first
    // clock after reset release via out_of_reset
    always_comb begin
        next_state           = state;
        packet_in_ready      = 1'b0;
        state_rd_en          = 1'b0;
        state_wr_en          = 1'b0;
        handler_packet_valid = 1'b0;
        handler_receive_done = 1'b0;
        drop_idle            = 1'b0;
        complete             = 1'b0;
        timeout              = 1'b0;
        case (state)
            RX_IDLE: begin
                packet_in_ready = out_of_reset;
                if (out_of_reset && packet_in_valid) begin
                    if (32'(packet_in.dst_device) >= NUM_DEVICES) drop_idle  = 1'b1;
                    else                                          next_state = RX_READ;
                end
            end
            RX_READ: begin
                state_rd_en = 1'b1;
                next_state  = RX_CAPTURE;
            end
            RX_CAPTURE: next_state = RX_HANDLE;
            RX_HANDLE: begin
                handler_packet_valid = 1'b1;
                handler_receive_done = (tmo_cnt == 8'd0);
                if (handler_write_state_valid && handler_packet_handled) begin
                    complete   = 1'b1;
                    next_state = RX_WRITE;
                end else if (tmo_cnt == 8'(HANDLER_TIMEOUT)) begin
                    timeout    = 1'b1;
                    next_state = RX_IDLE;
                end
            end
            RX_WRITE: begin
                state_wr_en = 1'b1;
                next_state  = RX_IDLE;
            end
            default: next_state = RX_IDLE;
        endcase
    end

    // Packet, state and timeout registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q        <= '0;
            rd_state_q   <= '0;
            wr_state_q   <= '0;
            tmo_cnt      <= '0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (packet_in_ready && packet_in_valid) pkt_q <= packet_in;
            if (state == RX_CAPTURE) rd_state_q <= state_rd_data;
            if (complete) wr_state_q <= handler_write_state;
            if (state == RX_CAPTURE)
                tmo_cnt <= '0;
            else if (state == RX_HANDLE && !complete)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Wrapping statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_handled <= '0;
            stat_dropped <= '0;
        end else begin
            if (state == RX_WRITE)      stat_handled <= stat_handled + 32'd1;
            if (drop_idle || timeout)   stat_dropped <= stat_dropped + 16'd1;
        end
    end

    dircc_rts_tracker #(
        .NUM_DEVICES (NUM_DEVICES),
        .DEV_IDX_W   (DEV_IDX_W)
    ) u_rts (
        .clk       (clk),
        .reset     (reset),
        .set_en    (state == RX_WRITE),
        .set_idx   (dst_idx),
        .set_value (wr_state_q.user_state[DIRCC_RTS_BIT]),
        .clr_en    (rts_clear),
        .clr_idx   (rts_clear_idx),
        .flags     (rts_pending)
    );

endmodule

// File: tb/tb_dircc_receive_scheduler.sv
// Testbench for dircc_receive_scheduler: a state RAM and a scripted handler
// surround the DUT; expected memory, RTS flags and counters come from a
// per-packet reference model.
module tb_dircc_receive_scheduler;
    import dircc_types_pkg::*;

    localparam int unsigned NDEV = 4;
    localparam int unsigned TMO  = 3;
    localparam int unsigned IW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    packet_t         packet_in;
    logic            packet_in_valid;
    logic            packet_in_ready;
    logic            state_rd_en;
    logic [IW-1:0]   state_rd_addr;
    dircc_state_t    state_rd_data = '0;
    logic            state_wr_en;
    logic [IW-1:0]   state_wr_addr;
    dircc_state_t    state_wr_data;
    packet_t         handler_packet;
    logic            handler_packet_valid;
    logic            handler_receive_done;
    dircc_state_t    handler_read_state;
    dircc_state_t    handler_write_state;
    logic            handler_write_state_valid;
    logic            handler_packet_handled;
    logic [NDEV-1:0] rts_pending;
    logic            rts_clear;
    logic [IW-1:0]   rts_clear_idx;
    logic [31:0]     stat_handled;
    logic [15:0]     stat_dropped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0]     exp_mem [NDEV];
    logic [NDEV-1:0] exp_rts;
    int              exp_handled;
    int              exp_dropped;

    dircc_state_t ram [NDEV] = '{default: '0};

    always #5 clk = ~clk;

    dircc_receive_scheduler #(
        .NUM_DEVICES     (NDEV),
        .HANDLER_TIMEOUT (TMO)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .packet_in                 (packet_in),
        .packet_in_valid           (packet_in_valid),
        .packet_in_ready           (packet_in_ready),
        .state_rd_en               (state_rd_en),
        .state_rd_addr             (state_rd_addr),
        .state_rd_data             (state_rd_data),
        .state_wr_en               (state_wr_en),
        .state_wr_addr             (state_wr_addr),
        .state_wr_data             (state_wr_data),
        .handler_packet            (handler_packet),
        .handler_packet_valid      (handler_packet_valid),
        .handler_receive_done      (handler_receive_done),
        .handler_read_state        (handler_read_state),
        .handler_write_state       (handler_write_state),
        .handler_write_state_valid (handler_write_state_valid),
        .handler_packet_handled    (handler_packet_handled),
        .rts_pending               (rts_pending),
        .rts_clear                 (rts_clear),
        .rts_clear_idx             (rts_clear_idx),
        .stat_handled              (stat_handled),
        .stat_dropped              (stat_dropped)
    );

    // State RAM with one-cycle read latency
    always @(posedge clk) begin
        if (state_rd_en) state_rd_data <= ram[state_rd_addr];
        if (state_wr_en) ram[state_wr_addr] <= state_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        exp_rts     = '0;
        exp_handled = 0;
        exp_dropped = 0;
    endtask

    // One packet through the scheduler. delay: HANDLE cycle index (0-based) at
    // which the handler completes, -1 for never. clr_mode bit0: rts_clear of
    // dst in the WRITE cycle; bit1: rts_clear of dst the cycle after.
    task automatic run_packet(input logic [7:0] dst, input int delay, input logic rtsv,
                              input int clr_mode, output int t_acc);
        packet_t     p;
        logic [15:0] nst;
        int          n;
        int          idx;
        int          r;
        logic        saw_wr;
        p.dst_device = dst;
        p.src_device = 8'($urandom);
        p.payload    = 16'($urandom);
        n = 0;
        while (!packet_in_ready && n < 20) begin tick(); n++; end
        checks++;
        if (packet_in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_wait got %b exp 1", packet_in_ready);
        end
        t_acc = cyc;
        packet_in = p; packet_in_valid = 1'b1;
        tick();
        packet_in = '0; packet_in_valid = 1'b0;
        if (32'(dst) >= NDEV) begin
            exp_dropped++;
            checks++;
            if (state_rd_en !== 1'b0 || packet_in_ready !== 1'b1 || stat_dropped !== 16'(exp_dropped)) begin
                errors++;
                $display("FAIL drop_range got rd_en=%b ready=%b dropped=%0d exp rd_en=0 ready=1 dropped=%0d",
                         state_rd_en, packet_in_ready, stat_dropped, exp_dropped);
            end
            return;
        end
        idx = int'(dst);
        checks++;
        if (state_rd_en !== 1'b1 || state_rd_addr !== IW'(idx)) begin
            errors++; $display("FAIL read_issue got en=%b addr=%0d exp en=1 addr=%0d", state_rd_en, state_rd_addr, idx);
        end
        tick();
        checks++;
        if (state_rd_en !== 1'b0 || handler_packet_valid !== 1'b0) begin
            errors++; $display("FAIL capture_cycle got rd_en=%b hpv=%b exp 0 0", state_rd_en, handler_packet_valid);
        end
        tick();
        checks++;
        if (handler_receive_done !== 1'b1 || handler_packet_valid !== 1'b1 ||
            handler_read_state.user_state !== exp_mem[idx] || handler_packet !== p) begin
            errors++;
            $display("FAIL handle_entry got done=%b hpv=%b state=%h pkt=%h exp done=1 hpv=1 state=%h pkt=%h",
                     handler_receive_done, handler_packet_valid, handler_read_state, handler_packet, exp_mem[idx], p);
        end
        nst = {rtsv, 15'(exp_mem[idx][14:0] + 15'd1)};
        saw_wr = 1'b0;
        for (int d = 0; d <= int'(TMO); d++) begin
            if (d > 0) begin
                checks++;
                if (handler_receive_done !== 1'b0 || handler_packet_valid !== 1'b1) begin
                    errors++; $display("FAIL handle_hold d=%0d got done=%b hpv=%b exp 0 1", d, handler_receive_done, handler_packet_valid);
                end
            end
            saw_wr = saw_wr | state_wr_en;
            if (d == delay) begin
                handler_write_state_valid = 1'b1; handler_packet_handled = 1'b1;
                handler_write_state.user_state = nst;
            end else begin
                r = int'($urandom_range(0, 2));
                handler_write_state_valid = (r == 1); handler_packet_handled = (r == 2);
                handler_write_state.user_state = 16'($urandom);
            end
            tick();
            handler_write_state_valid = 1'b0; handler_packet_handled = 1'b0;
            if (d == delay) break;
        end
        if (delay >= 0) begin
            checks++;
            if (state_wr_en !== 1'b1 || state_wr_addr !== IW'(idx) || state_wr_data.user_state !== nst ||
                handler_packet_valid !== 1'b0 || saw_wr !== 1'b0) begin
                errors++;
                $display("FAIL write_back got en=%b addr=%0d data=%h hpv=%b early=%b exp en=1 addr=%0d data=%h hpv=0 early=0",
                         state_wr_en, state_wr_addr, state_wr_data, handler_packet_valid, saw_wr, idx, nst);
            end
            exp_mem[idx] = nst;
            exp_handled++;
            exp_rts[idx] = rtsv;
            if (clr_mode[0]) begin rts_clear = 1'b1; rts_clear_idx = IW'(idx); end
            tick();
            rts_clear = 1'b0;
            checks++;
            if (packet_in_ready !== 1'b1 || stat_handled !== 32'(exp_handled) || rts_pending !== exp_rts) begin
                errors++;
                $display("FAIL after_write got ready=%b handled=%0d rts=%b exp ready=1 handled=%0d rts=%b",
                         packet_in_ready, stat_handled, rts_pending, exp_handled, exp_rts);
            end
            if (clr_mode[1]) begin
                rts_clear = 1'b1; rts_clear_idx = IW'(idx);
                tick();
                rts_clear = 1'b0;
                exp_rts[idx] = 1'b0;
                checks++;
                if (rts_pending !== exp_rts) begin
                    errors++; $display("FAIL rts_clear_late got %b exp %b", rts_pending, exp_rts);
                end
            end
        end else begin
            exp_dropped++;
            checks++;
            if (packet_in_ready !== 1'b1 || state_wr_en !== 1'b0 || handler_packet_valid !== 1'b0 ||
                saw_wr !== 1'b0 || stat_dropped !== 16'(exp_dropped)) begin
                errors++;
                $display("FAIL timeout_drop got ready=%b wr=%b hpv=%b early=%b dropped=%0d exp 1 0 0 0 %0d",
                         packet_in_ready, state_wr_en, handler_packet_valid, saw_wr, stat_dropped, exp_dropped);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        model_reset();
        checks++;
        if (packet_in_ready !== 1'b0 || state_rd_en !== 1'b0 || state_wr_en !== 1'b0 ||
            handler_packet_valid !== 1'b0 || handler_receive_done !== 1'b0 || rts_pending !== '0 ||
            stat_handled !== '0 || stat_dropped !== '0 || handler_packet !== '0 ||
            handler_read_state !== '0 || state_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%b rd=%b wr=%b hpv=%b done=%b rts=%b h=%0d d=%0d exp all 0",
                     packet_in_ready, state_rd_en, state_wr_en, handler_packet_valid, handler_receive_done,
                     rts_pending, stat_handled, stat_dropped);
        end
        reset = 1'b0;
        checks++;
        if (packet_in_ready !== 1'b0) begin
            errors++; $display("FAIL ready_release got %b exp 0", packet_in_ready);
        end
        tick();
        checks++;
        if (packet_in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_release got %b exp 1", packet_in_ready);
        end
    endtask

    task automatic test_single();
        int t;
        run_packet(8'd2, 1, 1'b1, 0, t);
    endtask

    task automatic test_drop_range();
        int t;
        run_packet(8'd7, 0, 1'b0, 0, t);
        run_packet(8'd255, 0, 1'b0, 0, t);
    endtask

    task automatic test_timeout();
        int t;
        run_packet(8'd3, -1, 1'b1, 0, t);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        run_packet(8'd1, 1, 1'b0, 0, t1);
        run_packet(8'd1, 1, 1'b1, 0, t2);
        checks++;
        if (t2 - t1 != 6) begin
            errors++; $display("FAIL b2b_interval got %0d exp 6", t2 - t1);
        end
    endtask

    task automatic test_rts_clear();
        int t;
        run_packet(8'd1, 2, 1'b1, 3, t);
        run_packet(8'd0, 3, 1'b1, 1, t);
    endtask

    task automatic test_reset_mid();
        packet_t p;
        int      n;
        n = 0;
        while (!packet_in_ready && n < 20) begin tick(); n++; end
        p.dst_device = 8'($urandom_range(0, NDEV - 1));
        p.src_device = 8'($urandom);
        p.payload    = 16'($urandom);
        packet_in = p; packet_in_valid = 1'b1;
        tick();
        packet_in = '0; packet_in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (handler_packet_valid !== 1'b1) begin
            errors++; $display("FAIL mid_in_handle got hpv=%b exp 1", handler_packet_valid);
        end
        reset = 1'b1;
        handler_write_state_valid = 1'b1; handler_packet_handled = 1'b1;
        handler_write_state.user_state = 16'($urandom);
        tick();
        handler_write_state_valid = 1'b0; handler_packet_handled = 1'b0;
        model_reset();
        checks++;
        if (handler_packet_valid !== 1'b0 || state_wr_en !== 1'b0 || packet_in_ready !== 1'b0 ||
            handler_packet !== '0 || handler_read_state !== '0 || state_wr_data !== '0 ||
            rts_pending !== '0 || stat_handled !== '0 || stat_dropped !== '0) begin
            errors++;
            $display("FAIL mid_reset got hpv=%b wr=%b ready=%b rts=%b h=%0d d=%0d exp all 0",
                     handler_packet_valid, state_wr_en, packet_in_ready, rts_pending, stat_handled, stat_dropped);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (packet_in_ready !== 1'b1 || state_wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_release got ready=%b wr=%b exp 1 0", packet_in_ready, state_wr_en);
        end
    endtask

    task automatic test_random();
        int          t;
        int          r;
        logic [7:0]  dst;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) dst = 8'(r % int'(NDEV));
            else       dst = 8'($urandom_range(NDEV, 255));
            run_packet(dst, int'($urandom_range(0, TMO + 1)) - 1, 1'($urandom), int'($urandom_range(0, 3)), t);
        end
    endtask

    initial begin
        reset = 1'b1;
        packet_in = '0;
        packet_in_valid = 1'b0;
        handler_write_state = '0;
        handler_write_state_valid = 1'b0;
        handler_packet_handled = 1'b0;
        rts_clear = 1'b0;
        rts_clear_idx = '0;
        for (int i = 0; i < int'(NDEV); i++) exp_mem[i] = '0;
        model_reset();
        test_reset();
        test_single();
        test_drop_range();
        test_timeout();
        test_back_to_back();
        test_rts_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_receive_scheduler.md
# dircc_receive_scheduler

Sequences the per-device receive path of a DiRCC processing element. Accepts packets from the NoC ingress, reads the addressed device's state from the device-state memory, presents packet and state to the receive handler, and writes the updated state back. Tracks per-device ready-to-send (RTS) flags for the send path. Sits between the router port, the state RAM and the `dircc_*_receive_handler` instance.

## Interface
- `NUM_DEVICES`, default 4: devices hosted by this element; valid range 2..256.
- `DEV_IDX_W`, default `$clog2(NUM_DEVICES)`: device index width.
- `HANDLER_TIMEOUT`, default 15: maximum HANDLE cycles before a packet is dropped; range 1..255.
- `clk` in 1: single clock; all logic is posedge.
- `reset` in 1: synchronous, active-high.
- `packet_in` in `packet_t`: ingress packet; `dst_device` field selects the device.
- `packet_in_valid` in 1 / `packet_in_ready` out 1: ingress handshake.
- `state_rd_en` out 1, `state_rd_addr` out `DEV_IDX_W`, `state_rd_data` in `dircc_state_t`: state RAM read port, 1-cycle read latency.
- `state_wr_en` out 1, `state_wr_addr` out `DEV_IDX_W`, `state_wr_data` out `dircc_state_t`: state RAM write port.
- `handler_packet` out `packet_t`, `handler_packet_valid` out 1, `handler_receive_done` out 1, `handler_read_state` out `dircc_state_t`: outputs to the handler.
- `handler_write_state` in `dircc_state_t`, `handler_write_state_valid` in 1, `handler_packet_handled` in 1: handler result.
- `rts_pending` out `NUM_DEVICES`: per-device RTS flags.
- `rts_clear` in 1, `rts_clear_idx` in `DEV_IDX_W`: send path clears one flag.
- `stat_handled` out 32: packets written back. `stat_dropped` out 16: packets dropped. Both counters wrap.

## Operation
- FSM states: IDLE, READ, CAPTURE, HANDLE, WRITE.
- IDLE
  - `packet_in_ready`=1.
  - On `packet_in_valid`, register the packet.
  - If `dst_device` >= `NUM_DEVICES`, drop it: `stat_dropped`++ and stay in IDLE.
  - Otherwise go to READ.
- READ: `state_rd_en`=1 and `state_rd_addr`=dst for one cycle; go to CAPTURE.
- CAPTURE: latch `state_rd_data` into a state register; go to HANDLE.
- HANDLE
  - `handler_packet_valid`=1 and `handler_packet`/`handler_read_state` are driven from registers for the whole state.
  - `handler_receive_done` pulses on the first HANDLE cycle only.
  - When `handler_write_state_valid` and `handler_packet_handled` are both high, latch `handler_write_state` and go to WRITE.
  - If only one of the two is high, hold state and count that cycle toward the timeout.
  - When the timeout counter reaches `HANDLER_TIMEOUT` with no completion: `stat_dropped`++, no write, go to IDLE.
- WRITE
  - `state_wr_en`=1 for one cycle, addr=dst, data=latched state.
  - `stat_handled`++.
  - `rts_pending[dst]` is set to bit `DIRCC_RTS_BIT` of `user_state`.
  - Go to IDLE.
- RTS update rules:
  - `rts_clear` clears `rts_clear_idx` in any state.
  - An out-of-range clear index is ignored.
  - A clear and a WRITE update to the same index in the same cycle: the WRITE value wins.
- No read-after-write hazard: the write completes before the next read is issued.
- Reset mid-operation: the in-flight packet is discarded without a write; the handler sees `handler_packet_valid` fall on the next cycle.

## Timing
- Reset values:
  - FSM=IDLE.
  - `packet_in_ready`, `state_rd_en`, `state_wr_en`, `handler_packet_valid`, `handler_receive_done` = 0.
  - `rts_pending`, `stat_*` = 0.
  - Registered data outputs = 0.
- `packet_in_ready` stays 0 during reset and rises the cycle after `reset` falls.
- Accept at cycle T. Then: `state_rd_en` T+1, data captured T+2, `handler_receive_done` T+3.
- With a 1-cycle handler (done at T+4): write at T+5, `packet_in_ready` high again at T+6. Minimum initiation interval is 6 cycles.
- The timeout counter starts at 0 on entry to HANDLE. The drop decision is taken in the cycle the counter equals `HANDLER_TIMEOUT`.

## Structure
- Already in `dircc_types_pkg`: `packet_t` (which carries `dst_device`) and `dircc_state_t`.
- Add to `dircc_types_pkg`: `DIRCC_RTS_BIT` and the enum `dircc_rx_sched_state_t`.
- One sub-module: `dircc_rts_tracker` (flag vector with set/clear priority).

## Test plan
- Single packet, dst=2, handler returns `user_state` with count+1 and rts=1 one cycle after `handler_receive_done` -> `state_wr_en` at T+5 with addr 2, `rts_pending`=4'b0100, `stat_handled`=1.
- Packet with dst=7 and `NUM_DEVICES`=4 -> accepted and dropped, no `state_rd_en`, `stat_dropped`=1, ready stays high.
- Handler never responds, `HANDLER_TIMEOUT`=3 -> no write, `stat_dropped`=1, back to IDLE 4 cycles after entering HANDLE.
- Back-to-back packets to dev 1 with counts 0 and 1 -> second read sees the first write (count 1), final count=2, ready gaps exactly 6 cycles.
- `rts_clear` of idx 1 in the same cycle as WRITE setting rts for dev 1 -> `rts_pending[1]`=1. A clear one cycle later -> 0.
- `reset` asserted during HANDLE -> no write, all outputs 0 next cycle, ready=1 the cycle after reset release.
